// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase generator.
// LFSR constants are used only when DDS_PHASE_DITHER_EN is defined.
package dds_pkg;

    localparam int ACC_WIDTH       = 32;
    localparam int ANGLE_WIDTH     = 20;
    localparam int SWEEP_CNT_WIDTH = 16;
    localparam int FULL_CIRCLE     = 1 << ANGLE_WIDTH;

    localparam int                    LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED  = 16'hACE1;
    // Taps 16/14/13/11 expressed as bit positions 15/13/12/10.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic {
        RUN   = 1'b0,
        SWEEP = 1'b1
    } state_e;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
        input logic [LFSR_WIDTH-1:0] s
    );
        return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dds_phase_lfsr.sv
// Fibonacci LFSR that provides truncation dither for the phase output.
// Instantiated only when DDS_PHASE_DITHER_EN is defined.
module dds_phase_lfsr
    import dds_pkg::*;
#(
    parameter int OUT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    output logic [OUT_WIDTH-1:0] dither_o
);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither_o = lfsr_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator with config handshake and linear FTW sweep.
// Define DDS_PHASE_DITHER_EN to add LFSR dither before truncation.
module dds_phase_acc #(
    parameter int ACC_WIDTH       = dds_pkg::ACC_WIDTH,
    parameter int ANGLE_WIDTH     = dds_pkg::ANGLE_WIDTH,
    parameter int SWEEP_CNT_WIDTH = dds_pkg::SWEEP_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       phase_clr,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [ACC_WIDTH-1:0]       cfg_ftw,
    input  logic [ANGLE_WIDTH-1:0]     cfg_pow,
    input  logic [ACC_WIDTH-1:0]       cfg_step,
    input  logic [SWEEP_CNT_WIDTH-1:0] cfg_len,
    input  logic                       sweep_start,
    output logic [ANGLE_WIDTH-1:0]     angle_o,
    output logic                       angle_valid_o,
    output logic                       sweep_busy_o,
    output logic                       sweep_done_o
);

    import dds_pkg::*;

    localparam int DITHER_WIDTH = ACC_WIDTH - ANGLE_WIDTH;

    state_e                     state_q, state_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [ACC_WIDTH-1:0]       ftw_q, ftw_d;
    logic [ACC_WIDTH-1:0]       step_q, step_d;
    logic [ANGLE_WIDTH-1:0]     pow_q, pow_d;
    logic [SWEEP_CNT_WIDTH-1:0] len_q, len_d;
    logic [SWEEP_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ANGLE_WIDTH-1:0]     angle_q, angle_d;
    logic                       valid_q;
    logic                       ready_q, ready_d;
    logic                       done_q, done_d;
    logic                       hs;
    logic [ANGLE_WIDTH-1:0]     trunc;

    assign hs = cfg_valid & ready_q;

`ifdef DDS_PHASE_DITHER_EN
    logic [DITHER_WIDTH-1:0] dither;
    logic [ACC_WIDTH-1:0]    dith_sum;

    dds_phase_lfsr #(
        .OUT_WIDTH(DITHER_WIDTH)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .dither_o(dither)
    );

    assign dith_sum = acc_q + {{ANGLE_WIDTH{1'b0}}, dither};
    assign trunc    = dith_sum[ACC_WIDTH-1 -: ANGLE_WIDTH];
`else
    assign trunc = acc_q[ACC_WIDTH-1 -: ANGLE_WIDTH];
`endif

    // A config accepted in the same cycle as sweep_start feeds the sweep.
    always_comb begin
        state_d = state_q;
        ftw_d   = ftw_q;
        pow_d   = pow_q;
        step_d  = step_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (hs) begin
            ftw_d  = cfg_ftw;
            pow_d  = cfg_pow;
            step_d = cfg_step;
            len_d  = cfg_len;
        end
        if (en) begin
            unique case (state_q)
                RUN: begin
                    if (sweep_start) begin
                        if (len_d != '0) begin
                            state_d = SWEEP;
                            cnt_d   = len_d;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    ftw_d = ftw_q + step_q;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == SWEEP_CNT_WIDTH'(1)) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        acc_d   = acc_q;
        angle_d = angle_q;
        ready_d = (state_d == RUN);
        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ftw_q;
        end
        if (en) begin
            angle_d = trunc + pow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            acc_q   <= '0;
            ftw_q   <= '0;
            step_q  <= '0;
            pow_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            angle_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            step_q  <= step_d;
            pow_q   <= pow_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            valid_q <= en;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign cfg_ready     = ready_q;
    assign angle_o       = angle_q;
    assign angle_valid_o = valid_q;
    assign sweep_busy_o  = (state_q == SWEEP);
    assign sweep_done_o  = done_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Directed self-checking bench for dds_phase_acc (default build).
module tb_dds_phase_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        phase_clr = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_ftw = '0;
    logic [19:0] cfg_pow = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_len = '0;
    logic        sweep_start = 1'b0;
    logic [19:0] angle_o;
    logic        angle_valid_o;
    logic        sweep_busy_o;
    logic        sweep_done_o;

    int tests = 0;
    int fails = 0;

    dds_phase_acc dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .phase_clr    (phase_clr),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ftw      (cfg_ftw),
        .cfg_pow      (cfg_pow),
        .cfg_step     (cfg_step),
        .cfg_len      (cfg_len),
        .sweep_start  (sweep_start),
        .angle_o      (angle_o),
        .angle_valid_o(angle_valid_o),
        .sweep_busy_o (sweep_busy_o),
        .sweep_done_o (sweep_done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [31:0] ftw, input logic [19:0] pow,
                       input logic [31:0] step, input logic [15:0] len);
        cfg_valid = 1'b1;
        cfg_ftw   = ftw;
        cfg_pow   = pow;
        cfg_step  = step;
        cfg_len   = len;
        tick();
        cfg_valid = 1'b0;
    endtask

    logic [19:0] sw_angle [1:7];

    initial begin
        sw_angle[1] = 20'h0;
        sw_angle[2] = 20'h0;
        sw_angle[3] = 20'h100;
        sw_angle[4] = 20'h300;
        sw_angle[5] = 20'h600;
        sw_angle[6] = 20'hA00;
        sw_angle[7] = 20'hE00;

        tick();
        tick();
        check("rst_angle", 32'(angle_o), 32'h0);
        check("rst_valid", 32'(angle_valid_o), 32'h0);
        check("rst_busy", 32'(sweep_busy_o), 32'h0);
        check("rst_done", 32'(sweep_done_o), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        tick();

        // ramp of 0x100 per cycle
        phase_clr = 1'b1;
        cfg(32'h0010_0000, 20'h0, 32'h0, 16'h0);
        phase_clr = 1'b0;
        en = 1'b1;
        tick();
        check("ramp_first", 32'(angle_o), 32'h0);
        check("ramp_valid", 32'(angle_valid_o), 32'h1);
        tick();
        check("ramp_second", 32'(angle_o), 32'h100);
        repeat (1023) tick();
        check("ramp_1024", 32'(angle_o), 32'h40000);

        en = 1'b0;
        tick();
        check("hold_valid", 32'(angle_valid_o), 32'h0);
        check("hold_angle", 32'(angle_o), 32'h40000);
        tick();
        check("hold_angle2", 32'(angle_o), 32'h40000);

        // half-circle FTW
        phase_clr = 1'b1;
        cfg(32'h8000_0000, 20'h0, 32'h0, 16'h0);
        phase_clr = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("half_alt", 32'(angle_o), (i % 2) ? 32'h80000 : 32'h0);
        end

        // constant offset
        en = 1'b0;
        phase_clr = 1'b1;
        cfg(32'h0, 20'h40000, 32'h0, 16'h0);
        phase_clr = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pow_const", 32'(angle_o), 32'h40000);
        end

        // phase_clr with en
        cfg(32'h1000, 20'h0, 32'h0, 16'h0);
        repeat (3) tick();
        phase_clr = 1'b1;
        tick();
        check("clr_pre", 32'(angle_o), 32'h3);
        phase_clr = 1'b0;
        tick();
        check("clr_zero", 32'(angle_o), 32'h0);
        tick();
        check("clr_one", 32'(angle_o), 32'h1);

        // sweep of 4 with config in the same cycle
        phase_clr = 1'b1;
        sweep_start = 1'b1;
        cfg(32'h0, 20'h0, 32'h0010_0000, 16'd4);
        phase_clr = 1'b0;
        sweep_start = 1'b0;
        check("sw_ready0", 32'(cfg_ready), 32'h0);
        check("sw_busy0", 32'(sweep_busy_o), 32'h1);
        check("sw_done0", 32'(sweep_done_o), 32'h0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("sw_angle", 32'(angle_o), 32'(sw_angle[i]));
            check("sw_busy", 32'(sweep_busy_o), (i < 4) ? 32'h1 : 32'h0);
            check("sw_ready", 32'(cfg_ready), (i < 4) ? 32'h0 : 32'h1);
            check("sw_done", 32'(sweep_done_o), (i == 4) ? 32'h1 : 32'h0);
        end

        // zero-length sweep
        sweep_start = 1'b1;
        cfg(32'h0, 20'h0, 32'h0, 16'h0);
        sweep_start = 1'b0;
        check("len0_done", 32'(sweep_done_o), 32'h1);
        check("len0_busy", 32'(sweep_busy_o), 32'h0);
        check("len0_ready", 32'(cfg_ready), 32'h1);
        tick();
        check("len0_pulse", 32'(sweep_done_o), 32'h0);

        // reset during the second sweep cycle
        sweep_start = 1'b1;
        cfg(32'h0010_0000, 20'h12345, 32'h0010_0000, 16'd8);
        sweep_start = 1'b0;
        tick();
        check("rs_busy", 32'(sweep_busy_o), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check("rs_angle", 32'(angle_o), 32'h0);
        check("rs_valid", 32'(angle_valid_o), 32'h0);
        check("rs_busy0", 32'(sweep_busy_o), 32'h0);
        check("rs_done", 32'(sweep_done_o), 32'h0);
        check("rs_ready", 32'(cfg_ready), 32'h1);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_nodone", 32'(sweep_done_o), 32'h0);
            check("rs_idle", 32'(sweep_busy_o), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
